// File: rtl/cache_data_array_pkg.sv
// Shared definitions for the N-way cache data store: default geometry,
// derived widths and the line-fill state encoding.
package cache_data_array_pkg;

  localparam int IDX_W_DEF  = 6;
  localparam int OFS_W_DEF  = 2;
  localparam int WORD_W_DEF = 32;
  localparam int WAYS_DEF   = 2;

  // Way-select width; a single-way cache still carries a 1-bit select.
  function automatic int calc_way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // One byte-enable bit per byte of a word.
  function automatic int calc_be_w(input int word_w);
    return word_w / 8;
  endfunction

  typedef enum logic [1:0] {
    FILL_IDLE   = 2'd0,
    FILL_ACTIVE = 2'd1,
    FILL_DONE   = 2'd2
  } fill_state_e;

endpackage

// File: rtl/cache_data_way.sv
// One way of the cache data store: byte-enabled synchronous write,
// registered read, and write-first forwarding when both ports hit the
// same word in the same cycle.
module cache_data_way
  import cache_data_array_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int OFS_W  = OFS_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             rd_en,
  input  logic [IDX_W+OFS_W-1:0]           rd_addr,
  output logic [WORD_W-1:0]                rd_data,
  input  logic                             wr_en,
  input  logic [IDX_W+OFS_W-1:0]           wr_addr,
  input  logic [calc_be_w(WORD_W)-1:0]     wr_be,
  input  logic [WORD_W-1:0]                wr_data
);

  localparam int AW    = IDX_W + OFS_W;
  localparam int BE_W  = calc_be_w(WORD_W);
  localparam int DEPTH = 2 ** AW;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_data_d, rd_data_q;

  // Array update: only enabled bytes of the addressed word change.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Read word selection with same-address write data merged in (write-first).
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
      if (wr_en && (wr_addr == rd_addr)) begin
        for (int b = 0; b < BE_W; b++) begin
          if (wr_be[b]) rd_data_d[b*8 +: 8] = wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Read output register; holds its value between reads.
  always_ff @(posedge clock) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/cache_data_array.sv
// N-way cache data store: parallel registered read of one word from every
// way, byte-enabled single-word writes, and a critical-word-first line
// fill engine that wraps around the line.
module cache_data_array
  import cache_data_array_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int OFS_W  = OFS_W_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int WAYS   = WAYS_DEF
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              rd_req,
  input  logic [IDX_W-1:0]                  rd_index,
  input  logic [OFS_W-1:0]                  rd_offset,
  output logic [WAYS*WORD_W-1:0]            rd_data,
  output logic                              rd_valid,
  input  logic                              wr_req,
  output logic                              wr_ready,
  input  logic [calc_way_w(WAYS)-1:0]       wr_way,
  input  logic [IDX_W-1:0]                  wr_index,
  input  logic [OFS_W-1:0]                  wr_offset,
  input  logic [calc_be_w(WORD_W)-1:0]      wr_be,
  input  logic [WORD_W-1:0]                 wr_data,
  input  logic                              fill_start,
  input  logic [calc_way_w(WAYS)-1:0]       fill_way,
  input  logic [IDX_W-1:0]                  fill_index,
  input  logic [OFS_W-1:0]                  fill_offset,
  input  logic                              fill_valid,
  input  logic [WORD_W-1:0]                 fill_data,
  output logic                              fill_busy,
  output logic                              fill_done
);

  localparam int WAY_W = calc_way_w(WAYS);
  localparam int BE_W  = calc_be_w(WORD_W);
  localparam int AW    = IDX_W + OFS_W;

  fill_state_e       state_q, state_d;
  logic [OFS_W-1:0]  cnt_q, cnt_d;
  logic [OFS_W-1:0]  ptr_q, ptr_d;
  logic [WAY_W-1:0]  fway_q, fway_d;
  logic [IDX_W-1:0]  fidx_q, fidx_d;
  logic              rd_valid_q, rd_valid_d;

  logic              fill_beat;
  logic              wr_commit;
  logic [AW-1:0]     mux_addr;
  logic [BE_W-1:0]   mux_be;
  logic [WORD_W-1:0] mux_data;

  assign fill_busy = (state_q != FILL_IDLE);
  assign fill_done = (state_q == FILL_DONE);
  assign wr_ready  = !fill_busy;
  assign wr_commit = wr_req && wr_ready;
  assign fill_beat = (state_q == FILL_ACTIVE) && fill_valid;
  assign rd_valid  = rd_valid_q;

  // Fill FSM next state: latch target on start, advance wrapping pointer per beat.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    fway_d     = fway_q;
    fidx_d     = fidx_q;
    rd_valid_d = rd_req;
    unique case (state_q)
      FILL_IDLE: begin
        if (fill_start) begin
          state_d = FILL_ACTIVE;
          cnt_d   = '0;
          ptr_d   = fill_offset;
          fway_d  = fill_way;
          fidx_d  = fill_index;
        end
      end
      FILL_ACTIVE: begin
        if (fill_valid) begin
          ptr_d = ptr_q + OFS_W'(1);
          cnt_d = cnt_q + OFS_W'(1);
          if (cnt_q == {OFS_W{1'b1}}) state_d = FILL_DONE;
        end
      end
      FILL_DONE: state_d = FILL_IDLE;
      default:   state_d = FILL_IDLE;
    endcase
  end

  // Control registers carry reset; the latched fill target does not need it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FILL_IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Fill target latch.
  always_ff @(posedge clock) begin
    fway_q <= fway_d;
    fidx_q <= fidx_d;
  end

  // Shared write port: a fill beat and a word write never coincide, since
  // word writes are refused while a fill is in progress.
  always_comb begin
    mux_addr = {wr_index, wr_offset};
    mux_be   = wr_be;
    mux_data = wr_data;
    if (fill_beat) begin
      mux_addr = {fidx_q, ptr_q};
      mux_be   = '1;
      mux_data = fill_data;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic way_wr_en;
    assign way_wr_en = (wr_commit && (wr_way == WAY_W'(w))) ||
                       (fill_beat && (fway_q == WAY_W'(w)));

    cache_data_way #(
      .IDX_W  (IDX_W),
      .OFS_W  (OFS_W),
      .WORD_W (WORD_W)
    ) u_way (
      .clock   (clock),
      .reset   (reset),
      .rd_en   (rd_req),
      .rd_addr ({rd_index, rd_offset}),
      .rd_data (rd_data[w*WORD_W +: WORD_W]),
      .wr_en   (way_wr_en),
      .wr_addr (mux_addr),
      .wr_be   (mux_be),
      .wr_data (mux_data)
    );
  end

endmodule

// File: doc/cache_data_array.md
Name: cache_data_array

Overview:
- Parametrised N-way cache data store; successor to the single-way, whole-block data RAM.
- Provides a registered read of one word from every way at once.
- Provides byte-enabled single-word writes into one selected way.
- Provides a line-fill engine that streams a full line from memory critical-word-first, wrapping around the line.
- Sits between the cache controller (tag compare / way select) and the memory bus refill path.

Parameters:
- IDX_W, 6, set index width; sets = 2**IDX_W
- OFS_W, 2, word-offset width; words per line = 2**OFS_W
- WORD_W, 32, word width in bits; must be a multiple of 8
- WAYS, 2, associativity; way select width WAY_W = max(1, clog2(WAYS))

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- rd_req  in  1  read request
- rd_index  in  IDX_W  read set
- rd_offset  in  OFS_W  read word
- rd_data  out  WAYS*WORD_W  way w at bits [w*WORD_W +: WORD_W]
- rd_valid  out  1  rd_data valid
- wr_req  in  1  word write request
- wr_ready  out  1  write accepted this cycle
- wr_way  in  WAY_W  target way
- wr_index  in  IDX_W  target set
- wr_offset  in  OFS_W  target word
- wr_be  in  WORD_W/8  byte enables
- wr_data  in  WORD_W  write data
- fill_start  in  1  begin line fill
- fill_way  in  WAY_W  fill way
- fill_index  in  IDX_W  fill set
- fill_offset  in  OFS_W  first (critical) word
- fill_valid  in  1  fill beat present
- fill_data  in  WORD_W  fill beat data
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse after last beat

Behaviour:
- Reset values:
  - rd_valid=0, rd_data=0.
  - fill_busy=0, fill_done=0, wr_ready=1.
  - FSM=IDLE, beat counter=0.
  - Array contents are not cleared.
- Read:
  - rd_req sampled at posedge N; rd_data and rd_valid registered at posedge N+1 (latency 1).
  - rd_valid deasserts the cycle after a cycle without rd_req.
  - rd_data holds its last value when rd_valid=0.
- Write:
  - wr_ready = !fill_busy (combinational).
  - A write commits at posedge when wr_req && wr_ready.
  - Only bytes with wr_be[b]=1 update; wr_be=0 is a no-op.
- Read/write collision:
  - Write-first.
  - When a read and a committing write or fill beat hit the same index/offset in the same cycle, rd_data for the written way returns the post-write merged word; other ways are unaffected.
- Fill FSM, states IDLE, FILL, DONE:
  - IDLE -> FILL on fill_start: latch way/index; counter = 0; word pointer = fill_offset.
  - FILL: each fill_valid writes fill_data, all bytes, at pointer; pointer increments modulo 2**OFS_W (wrap-around, e.g. start 2 with 4 words -> 2,3,0,1); counter increments.
  - fill_valid low stalls the fill with no write.
  - FILL -> DONE on the beat where counter == 2**OFS_W-1.
  - DONE: fill_done=1 for exactly one cycle -> IDLE.
  - fill_busy=1 in FILL and DONE.
  - fill_start outside IDLE is ignored.
  - fill_valid in IDLE or DONE is ignored.
  - fill_start in IDLE with fill_valid in the same cycle: the beat is ignored; the first beat is accepted from the next cycle.
- Reads are always permitted during fill, including on the line being filled: words not yet written return old contents; the bypass applies to the in-flight beat.
- Reset mid-fill: FSM -> IDLE, no fill_done pulse, partially written words remain.

Decomposition:
- Shared cache package:
  - IDX_W/OFS_W/WORD_W/WAYS defaults.
  - Derived WAY_W and BE_W.
  - Fill-state encoding (IDLE=0, FILL=1, DONE=2).
- One sub-module, cache_data_way:
  - Single-way WORD_W x 2**(IDX_W+OFS_W) array.
  - Byte-enabled synchronous write, registered read, write-first bypass.
  - Instantiated WAYS times.
- The fill FSM lives in the top level.

Test Plan (defaults: WAYS=2, OFS_W=2, WORD_W=32):
- Write/read: wr way1 idx5 ofs3 be=F data=DEADBEEF; rd idx5 ofs3 next cycle -> one cycle later rd_valid=1, rd_data[63:32]=DEADBEEF, way0 word unchanged.
- Byte enables: preload 11223344; wr be=4'b0101 data=AABBCCDD -> readback 11BB33DD.
- Wrap fill: fill_start way0 idx9 ofs2; beats A0,A1,A2,A3 with a 2-cycle fill_valid gap after A1:
  - words 2,3,0,1 = A0,A1,A2,A3.
  - fill_done pulses once, the cycle after A3.
  - wr_ready=0 throughout.
- Collision: same-cycle wr idx5 ofs0 way0 data=12345678 and rd idx5 ofs0 -> rd_data[31:0]=12345678.
- Reset mid-fill: reset after 2 of 4 beats:
  - fill_busy=0 next cycle, no fill_done.
  - The 2 written words are readable; the other 2 keep their old values.
- Ignored start: fill_start during FILL with a different index -> original fill completes untouched; the second index is unmodified.
